// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - round-robin N-to-1 AXI4-Lite arbiter, one transaction outstanding
module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                                         clk,
  input  logic                                         reset,
  // upstream masters
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]       m_araddr_i,
  input  logic [NUM_MASTERS-1:0]                       m_arvalid_i,
  output logic [NUM_MASTERS-1:0]                       m_arready_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]       m_rdata_o,
  output logic [NUM_MASTERS-1:0][1:0]                  m_rresp_o,
  output logic [NUM_MASTERS-1:0]                       m_rvalid_o,
  input  logic [NUM_MASTERS-1:0]                       m_rready_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]       m_awaddr_i,
  input  logic [NUM_MASTERS-1:0]                       m_awvalid_i,
  output logic [NUM_MASTERS-1:0]                       m_awready_o,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]       m_wdata_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]     m_wmask_i,
  input  logic [NUM_MASTERS-1:0]                       m_wvalid_i,
  output logic [NUM_MASTERS-1:0]                       m_wready_o,
  output logic [NUM_MASTERS-1:0][1:0]                  m_bresp_o,
  output logic [NUM_MASTERS-1:0]                       m_bvalid_o,
  input  logic [NUM_MASTERS-1:0]                       m_bready_i,
  // downstream slave port
  output logic [ADDR_WIDTH-1:0]                        s_araddr_o,
  output logic                                         s_arvalid_o,
  input  logic                                         s_arready_i,
  input  logic [DATA_WIDTH-1:0]                        s_rdata_i,
  input  logic [1:0]                                   s_rresp_i,
  input  logic                                         s_rvalid_i,
  output logic                                         s_rready_o,
  output logic [ADDR_WIDTH-1:0]                        s_awaddr_o,
  output logic                                         s_awvalid_o,
  input  logic                                         s_awready_i,
  output logic [DATA_WIDTH-1:0]                        s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                      s_wmask_o,
  output logic                                         s_wvalid_o,
  input  logic                                         s_wready_i,
  input  logic [1:0]                                   s_bresp_i,
  input  logic                                         s_bvalid_i,
  output logic                                         s_bready_o,
  // status
  output logic [$clog2(NUM_MASTERS)-1:0]               grant_idx_o,
  output logic                                         busy_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   found;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W:0]         cand;
  logic                   aw_hs, w_hs;

  // A master asks for the bus with either address valid; wvalid alone does not count.
  assign req = m_arvalid_i | m_awvalid_i;

  // Round-robin search starting one past the last completed master.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = (IDX_W+1)'(int'(last_q) + i);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) cand = cand - (IDX_W+1)'(NUM_MASTERS);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state logic and channel routing; only the granted master sees the slave.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    m_arready_o = '0;
    m_rdata_o   = '0;
    m_rresp_o   = '0;
    m_rvalid_o  = '0;
    m_awready_o = '0;
    m_wready_o  = '0;
    m_bresp_o   = '0;
    m_bvalid_o  = '0;
    s_araddr_o  = m_araddr_i[sel_q];
    s_awaddr_o  = m_awaddr_i[sel_q];
    s_wdata_o   = m_wdata_i[sel_q];
    s_wmask_o   = m_wmask_i[sel_q];
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    s_awvalid_o = 1'b0;
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = winner;
          state_d = m_arvalid_i[winner] ? RD_AR : WR_AWW;
        end
      end
      RD_AR: begin
        s_arvalid_o          = m_arvalid_i[sel_q];
        m_arready_o[sel_q]   = s_arready_i;
        if (m_arvalid_i[sel_q] && s_arready_i) state_d = RD_R;
      end
      RD_R: begin
        m_rvalid_o[sel_q] = s_rvalid_i;
        m_rdata_o[sel_q]  = s_rdata_i;
        m_rresp_o[sel_q]  = s_rresp_i;
        s_rready_o        = m_rready_i[sel_q];
        if (s_rvalid_i && m_rready_i[sel_q]) begin
          state_d = IDLE;
          last_d  = sel_q;
        end
      end
      WR_AWW: begin
        s_awvalid_o        = m_awvalid_i[sel_q] & ~aw_done_q;
        s_wvalid_o         = m_wvalid_i[sel_q] & ~w_done_q;
        m_awready_o[sel_q] = s_awready_i & ~aw_done_q;
        m_wready_o[sel_q]  = s_wready_i & ~w_done_q;
        aw_hs = m_awvalid_i[sel_q] & ~aw_done_q & s_awready_i;
        w_hs  = m_wvalid_i[sel_q] & ~w_done_q & s_wready_i;
        // Handshakes completing this cycle count, so no extra cycle is spent here.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      WR_B: begin
        m_bvalid_o[sel_q] = s_bvalid_i;
        m_bresp_o[sel_q]  = s_bresp_i;
        s_bready_o        = m_bready_i[sel_q];
        if (s_bvalid_i && m_bready_i[sel_q]) begin
          state_d = IDLE;
          last_d  = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last starts at the top index so master 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign grant_idx_o = sel_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - scoreboard bench for axi_lite_arbiter
module tb_axi_lite_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] RD_KEY = 32'h5EADBEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0]   m_araddr_i, m_awaddr_i;
  logic [N-1:0]           m_arvalid_i, m_arready_o, m_rvalid_o, m_rready_i;
  logic [N-1:0][DW-1:0]   m_rdata_o, m_wdata_i;
  logic [N-1:0][1:0]      m_rresp_o, m_bresp_o;
  logic [N-1:0]           m_awvalid_i, m_awready_o, m_wvalid_i, m_wready_o;
  logic [N-1:0][DW/8-1:0] m_wmask_i;
  logic [N-1:0]           m_bvalid_o, m_bready_i;
  logic [AW-1:0]          s_araddr_o, s_awaddr_o;
  logic                   s_arvalid_o, s_arready_i, s_rvalid_i, s_rready_o;
  logic [DW-1:0]          s_rdata_i, s_wdata_o;
  logic [1:0]             s_rresp_i, s_bresp_i;
  logic                   s_awvalid_o, s_awready_i, s_wvalid_o, s_wready_i;
  logic [DW/8-1:0]        s_wmask_o;
  logic                   s_bvalid_i, s_bready_o;
  logic [0:0]             grant_idx_o;
  logic                   busy_o;

  axi_lite_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m_araddr_i(m_araddr_i), .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o),
    .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
    .m_awaddr_i(m_awaddr_i), .m_awvalid_i(m_awvalid_i), .m_awready_o(m_awready_o),
    .m_wdata_i(m_wdata_i), .m_wmask_i(m_wmask_i), .m_wvalid_i(m_wvalid_i), .m_wready_o(m_wready_o),
    .m_bresp_o(m_bresp_o), .m_bvalid_o(m_bvalid_o), .m_bready_i(m_bready_i),
    .s_araddr_o(s_araddr_o), .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i),
    .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
    .s_awaddr_o(s_awaddr_o), .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
    .s_wdata_o(s_wdata_o), .s_wmask_o(s_wmask_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
    .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o),
    .grant_idx_o(grant_idx_o), .busy_o(busy_o)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb_q [N][$];
  int   grant_log[$];
  int   done_log[$];
  int   iso_viol = 0;

  function automatic logic [1:0] resp_for(input logic [31:0] addr);
    return (addr[3:0] == 4'hC) ? 2'b10 : 2'b00;
  endfunction

  // Downstream slave: zero-wait AR/W, programmable AW delay, registered R/B.
  int          aw_delay = 0;
  int          aw_cnt;
  logic        sl_rv, sl_bv, sl_aw_got, sl_w_got;
  logic [31:0] sl_rdata, sl_awaddr;
  logic [1:0]  sl_rresp, sl_bresp;
  logic        awhs, whs;

  assign s_arready_i = 1'b1;
  assign s_wready_i  = 1'b1;
  assign s_awready_i = (aw_cnt >= aw_delay);
  assign s_rvalid_i  = sl_rv;
  assign s_rdata_i   = sl_rdata;
  assign s_rresp_i   = sl_rresp;
  assign s_bvalid_i  = sl_bv;
  assign s_bresp_i   = sl_bresp;
  assign awhs        = s_awvalid_o && s_awready_i;
  assign whs         = s_wvalid_o && s_wready_i;

  always @(posedge clk) begin
    if (reset) begin
      sl_rv <= 1'b0; sl_bv <= 1'b0; sl_aw_got <= 1'b0; sl_w_got <= 1'b0;
      sl_rdata <= '0; sl_rresp <= '0; sl_bresp <= '0; sl_awaddr <= '0; aw_cnt <= 0;
    end else begin
      if (s_arvalid_o && s_arready_i) begin
        sl_rv <= 1'b1; sl_rdata <= s_araddr_o ^ RD_KEY; sl_rresp <= resp_for(s_araddr_o);
      end else if (sl_rv && s_rready_o) sl_rv <= 1'b0;
      if (s_awvalid_o && !s_awready_i) aw_cnt <= aw_cnt + 1;
      else if (awhs) aw_cnt <= 0;
      if (awhs) sl_awaddr <= s_awaddr_o;
      if (sl_bv && s_bready_o) sl_bv <= 1'b0;
      if ((sl_aw_got || awhs) && (sl_w_got || whs)) begin
        sl_bv <= 1'b1; sl_bresp <= resp_for(awhs ? s_awaddr_o : sl_awaddr);
        sl_aw_got <= 1'b0; sl_w_got <= 1'b0;
      end else begin
        sl_aw_got <= sl_aw_got | awhs; sl_w_got <= sl_w_got | whs;
      end
    end
  end

  // Observer: logs each new grant and counts cycles where a non-granted master sees activity.
  logic busy_d = 1'b0;
  always @(negedge clk) begin
    if (busy_o && !busy_d) grant_log.push_back(int'(grant_idx_o));
    busy_d <= busy_o;
    for (int i = 0; i < N; i++) begin
      if (!busy_o || int'(grant_idx_o) != i) begin
        if ({m_arready_o[i], m_awready_o[i], m_wready_o[i], m_rvalid_o[i], m_bvalid_o[i],
             m_rdata_o[i], m_rresp_o[i], m_bresp_o[i]} !== '0)
          iso_viol <= iso_viol + 1;
      end
    end
  end

  task automatic idle_inputs();
    m_araddr_i = '0; m_arvalid_i = '0; m_rready_i = '1;
    m_awaddr_i = '0; m_awvalid_i = '0; m_wdata_i = '0; m_wmask_i = '0; m_wvalid_i = '0;
    m_bready_i = '1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_read(input int mi, input logic [31:0] addr);
    exp_t e;
    bit   ok;
    e.is_wr = 1'b0; e.data = addr ^ RD_KEY; e.resp = resp_for(addr);
    sb_q[mi].push_back(e);
    m_araddr_i[mi] = addr; m_arvalid_i[mi] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (m_arready_o[mi]) ok = 1'b1;
    end
    @(posedge clk); #1;
    m_arvalid_i[mi] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_ar_timeout m%0d: arready never seen, required within 60 cycles", mi); end
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (m_rvalid_o[mi] && m_rready_i[mi]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rd_r_timeout m%0d: rvalid never seen, required within 60 cycles", mi);
    end else begin
      e = sb_q[mi].pop_front();
      if (m_rdata_o[mi] !== e.data || m_rresp_o[mi] !== e.resp) begin
        errors++;
        $display("FAIL rd_data m%0d: got %h/%b, required %h/%b", mi, m_rdata_o[mi], m_rresp_o[mi], e.data, e.resp);
      end
      done_log.push_back(mi * 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int mi, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    exp_t e;
    bit   aw_ok, w_ok, ok;
    e.is_wr = 1'b1; e.data = '0; e.resp = resp_for(addr);
    sb_q[mi].push_back(e);
    m_awaddr_i[mi] = addr; m_wdata_i[mi] = data; m_wmask_i[mi] = mask;
    m_awvalid_i[mi] = 1'b1; m_wvalid_i[mi] = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0;
    for (int c = 0; c < 60 && !(aw_ok && w_ok); c++) begin
      @(negedge clk);
      if (m_awvalid_i[mi] && m_awready_o[mi]) aw_ok = 1'b1;
      if (m_wvalid_i[mi] && m_wready_o[mi]) w_ok = 1'b1;
      @(posedge clk); #1;
      if (aw_ok) m_awvalid_i[mi] = 1'b0;
      if (w_ok) m_wvalid_i[mi] = 1'b0;
    end
    checks++;
    if (!(aw_ok && w_ok)) begin
      errors++; $display("FAIL wr_hs_timeout m%0d: aw=%0b w=%0b, required both within 60 cycles", mi, aw_ok, w_ok);
      m_awvalid_i[mi] = 1'b0; m_wvalid_i[mi] = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (m_bvalid_o[mi] && m_bready_i[mi]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wr_b_timeout m%0d: bvalid never seen, required within 60 cycles", mi);
    end else begin
      e = sb_q[mi].pop_front();
      if (m_bresp_o[mi] !== e.resp) begin
        errors++; $display("FAIL wr_bresp m%0d: got %b, required %b", mi, m_bresp_o[mi], e.resp);
      end
      done_log.push_back(mi * 2 + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    m_arvalid_i[0] = 1'b1; m_awvalid_i[1] = 1'b1; m_wvalid_i[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    checks++; if (grant_idx_o !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0d, required 0", grant_idx_o); end
    checks++; if ({s_arvalid_o, s_awvalid_o, s_wvalid_o, s_rready_o, s_bready_o} !== 5'b0) begin
      errors++; $display("FAIL reset_s_valids: got %b, required 00000", {s_arvalid_o, s_awvalid_o, s_wvalid_o, s_rready_o, s_bready_o}); end
    checks++; if ({m_arready_o, m_awready_o, m_wready_o, m_rvalid_o, m_bvalid_o} !== '0) begin
      errors++; $display("FAIL reset_m_outputs: got %b, required 0", {m_arready_o, m_awready_o, m_wready_o, m_rvalid_o, m_bvalid_o}); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_read();
    apply_reset();
    fork
      do_read(0, 32'h8000_0000);
      begin
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || s_arvalid_o !== 1'b0) begin errors++; $display("FAIL sr_c0: busy/arvalid=%b%b, required 00", busy_o, s_arvalid_o); end
        @(negedge clk);
        checks++; if (s_arvalid_o !== 1'b1 || s_araddr_o !== 32'h8000_0000) begin errors++; $display("FAIL sr_c1_ar: got %b/%h, required 1/80000000", s_arvalid_o, s_araddr_o); end
        checks++; if (busy_o !== 1'b1 || grant_idx_o !== 1'b0) begin errors++; $display("FAIL sr_c1_grant: busy/grant=%b/%0d, required 1/0", busy_o, grant_idx_o); end
        @(negedge clk);
        checks++; if (m_rvalid_o[0] !== 1'b1 || m_rdata_o[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_c2_r: got %b/%h, required 1/deadbeef", m_rvalid_o[0], m_rdata_o[0]); end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sr_c3_busy: got %b, required 0", busy_o); end
      end
    join
  endtask

  task automatic test_contention();
    int g0, v0;
    int exp_g[4] = '{0, 1, 0, 1};
    apply_reset();
    g0 = grant_log.size();
    v0 = iso_viol;
    fork
      begin do_read(0, 32'h1000_0000); do_read(0, 32'h1000_0004); end
      begin do_read(1, 32'h2000_0000); do_read(1, 32'h2000_000C); end
    join
    @(negedge clk);
    checks++;
    if (grant_log.size() - g0 != 4) begin
      errors++; $display("FAIL cont_grants: got %0d grants, required 4", grant_log.size() - g0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_log[g0 + k] != exp_g[k]) begin errors++; $display("FAIL cont_order[%0d]: got %0d, required %0d", k, grant_log[g0 + k], exp_g[k]); end
      end
    end
    checks++;
    if (iso_viol != v0) begin errors++; $display("FAIL cont_isolation: %0d leaked cycles, required 0", iso_viol - v0); end
    @(posedge clk); #1;
  endtask

  task automatic test_split_write();
    apply_reset();
    aw_delay = 3;
    fork
      do_write(1, 32'hA000_03F8, 32'h1234_5678, 4'b1111);
      begin
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_awvalid_o !== 1'b1 || s_wvalid_o !== 1'b1 || grant_idx_o !== 1'b1) begin errors++; $display("FAIL sw_c1: aw/w/grant=%b%b%0d, required 111", s_awvalid_o, s_wvalid_o, grant_idx_o); end
        checks++; if (s_wdata_o !== 32'h1234_5678 || s_awaddr_o !== 32'hA000_03F8 || s_wmask_o !== 4'hF) begin errors++; $display("FAIL sw_payload: got %h/%h/%h, required a00003f8/12345678/f", s_awaddr_o, s_wdata_o, s_wmask_o); end
        @(negedge clk);
        checks++; if (s_wvalid_o !== 1'b0 || s_awvalid_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL sw_c2: w/aw/busy=%b%b%b, required 011", s_wvalid_o, s_awvalid_o, busy_o); end
        @(negedge clk);
        checks++; if (s_awvalid_o !== 1'b1 || m_bvalid_o[1] !== 1'b0 || s_bready_o !== 1'b0) begin errors++; $display("FAIL sw_c3: aw/bvalid/bready=%b%b%b, required 100", s_awvalid_o, m_bvalid_o[1], s_bready_o); end
        @(negedge clk);
        checks++; if (s_awvalid_o !== 1'b1 || s_awready_i !== 1'b1 || m_bvalid_o[1] !== 1'b0) begin errors++; $display("FAIL sw_c4: aw/awready/bvalid=%b%b%b, required 110", s_awvalid_o, s_awready_i, m_bvalid_o[1]); end
        @(negedge clk);
        checks++; if (m_bvalid_o[1] !== 1'b1 || m_bresp_o[1] !== 2'b00 || s_bready_o !== 1'b1) begin errors++; $display("FAIL sw_c5_b: bvalid/bresp/bready=%b/%b/%b, required 1/00/1", m_bvalid_o[1], m_bresp_o[1], s_bready_o); end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sw_c6_busy: got %b, required 0", busy_o); end
      end
    join
    aw_delay = 0;
  endtask

  task automatic test_same_cycle_write();
    apply_reset();
    aw_delay = 0;
    fork
      do_write(0, 32'h1000_000C, 32'hCAFE_F00D, 4'b0101);
      begin
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_awvalid_o !== 1'b1 || s_wvalid_o !== 1'b1 || s_wmask_o !== 4'b0101) begin errors++; $display("FAIL sc_c1: aw/w/mask=%b%b/%b, required 11/0101", s_awvalid_o, s_wvalid_o, s_wmask_o); end
        @(negedge clk);
        checks++; if (m_bvalid_o[0] !== 1'b1 || m_bresp_o[0] !== 2'b10) begin errors++; $display("FAIL sc_c2_b: bvalid/bresp=%b/%b, required 1/10", m_bvalid_o[0], m_bresp_o[0]); end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sc_c3_busy: got %b, required 0", busy_o); end
      end
    join
  endtask

  task automatic test_read_precedence();
    int g0;
    apply_reset();
    g0 = grant_log.size();
    done_log.delete();
    fork
      do_read(0, 32'h2000_0004);
      do_write(0, 32'h2000_0008, 32'h0BAD_CAFE, 4'b0011);
      begin
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_arvalid_o !== 1'b1 || s_awvalid_o !== 1'b0) begin errors++; $display("FAIL rp_c1: ar/aw=%b%b, required 10", s_arvalid_o, s_awvalid_o); end
      end
    join
    @(negedge clk);
    checks++;
    if (grant_log.size() - g0 != 2 || grant_log[g0] != 0 || grant_log[g0 + 1] != 0) begin
      errors++; $display("FAIL rp_grants: got %0d grants, required two grants to m0", grant_log.size() - g0);
    end
    checks++;
    if (done_log.size() != 2 || done_log[0] != 0 || done_log[1] != 1) begin
      errors++; $display("FAIL rp_order: got %0d completions, required read then write", done_log.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    int g0;
    apply_reset();
    m_rready_i[1] = 1'b0;
    m_araddr_i[1] = 32'h3000_0010; m_arvalid_i[1] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (s_arvalid_o !== 1'b1 || grant_idx_o !== 1'b1) begin errors++; $display("FAIL rm_c1: ar/grant=%b/%0d, required 1/1", s_arvalid_o, grant_idx_o); end
    @(posedge clk); #1;
    m_arvalid_i[1] = 1'b0; m_rready_i[1] = 1'b1; reset = 1'b1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b1 || m_rvalid_o[1] !== 1'b1) begin errors++; $display("FAIL rm_c2_rd_r: busy/rvalid=%b%b, required 11", busy_o, m_rvalid_o[1]); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (s_rready_o !== 1'b0 || busy_o !== 1'b0 || m_rvalid_o !== '0 || m_bvalid_o !== '0) begin
      errors++; $display("FAIL rm_after_reset: rready/busy/rvalid/bvalid=%b/%b/%b/%b, required 0/0/00/00", s_rready_o, busy_o, m_rvalid_o, m_bvalid_o); end
    @(posedge clk); #1;
    g0 = grant_log.size();
    fork
      do_read(1, 32'h3000_0020);
      do_read(0, 32'h3000_0030);
    join
    @(negedge clk);
    checks++;
    if (grant_log.size() - g0 < 1 || grant_log[g0] != 0) begin
      errors++; $display("FAIL rm_first_grant: got %0d, required 0", (grant_log.size() > g0) ? grant_log[g0] : -1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_split_write();
    test_same_cycle_write();
    test_read_precedence();
    test_reset_mid_read();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sb_q[i].size() != 0) begin errors++; $display("FAIL sb_leftover m%0d: %0d pending, required 0", i, sb_q[i].size()); end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

N-to-1 AXI4-Lite arbiter that shares one downstream AXI4-Lite port (normally the `xbar` master side) between several upstream masters, e.g. IFU and LSU. One transaction is outstanding at a time, either a read or a write. The grant is round-robin and is held for the whole transaction. Non-granted masters are stalled with all ready and valid signals held low.

## Interface
- `NUM_MASTERS`, default 2: number of upstream masters, ≥2; index 0 has the highest priority after reset.
- `ADDR_WIDTH`, default 32: address width, passed through unchanged.
- `DATA_WIDTH`, default 32: data width, passed through unchanged; `wmask` is `DATA_WIDTH/8` bits.
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `m[NUM_MASTERS]`, `axi_lite_if.slave`: upstream masters.
  - AR channel: `araddr`, `arvalid`, `arready`.
  - R channel: `rdata`, `rresp`, `rvalid`, `rready`.
  - AW channel: `awaddr`, `awvalid`, `awready`.
  - W channel: `wdata`, `wmask`, `wvalid`, `wready`.
  - B channel: `bresp`, `bvalid`, `bready`.
- `s`, `axi_lite_if.master`: the single downstream port. Same signal set as `m`.
- `grant_idx`, output, `$clog2(NUM_MASTERS)`: index of the current or last granted master, for debug and perf counters.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: no transaction in progress.
  - RD_AR: read address being forwarded.
  - RD_R: waiting for read data.
  - WR_AWW: write address and write data being forwarded.
  - WR_B: waiting for write response.
- A master is requesting when `arvalid | awvalid`. `wvalid` alone is not a request.
- Arbitration in IDLE:
  - Candidates are searched starting at `(last + 1) mod NUM_MASTERS` and wrapping; the first requester wins.
  - `sel` and `grant_idx` are registered on the IDLE exit edge.
  - If the winner has `arvalid`, go to RD_AR. Otherwise go to WR_AWW. Read takes precedence over write for the same master.
- RD_AR:
  - `s.arvalid = m[sel].arvalid`, `s.araddr = m[sel].araddr`, `m[sel].arready = s.arready`.
  - On the AR handshake, go to RD_R.
- RD_R:
  - `m[sel].rvalid = s.rvalid`; `rdata` and `rresp` forwarded.
  - `s.rready = m[sel].rready`.
  - On the R handshake, go to IDLE and set `last <= sel`.
- WR_AWW:
  - AW and W are forwarded independently. Flags `aw_done` and `w_done` are set on their respective handshakes.
  - `s.awvalid = m[sel].awvalid & ~aw_done`; `s.wvalid = m[sel].wvalid & ~w_done`.
  - Readies are gated the same way.
  - Go to WR_B in the cycle where both handshakes are complete, counting handshakes made in that same cycle. Both flags clear on entry to WR_B.
- WR_B:
  - `bvalid`, `bresp` and `bready` are forwarded.
  - On the B handshake, go to IDLE and set `last <= sel`.
- Non-granted masters, and every master while in IDLE: `arready`, `awready`, `wready`, `rvalid`, `bvalid` are 0; `rdata` is 0; `rresp` and `bresp` are 2'b00.
- Payload to `s` (`araddr`, `awaddr`, `wdata`, `wmask`) is driven from `m[sel]` at all times. Only the valids are gated.
- Error responses (`rresp`/`bresp` ≠ 00) are passed through unchanged and do not affect sequencing.

## Timing
- Reset:
  - state = IDLE, `last = NUM_MASTERS-1` so master 0 wins first, `sel = 0`, `aw_done = w_done = 0`.
  - All `s` valids and readies are 0; all `m` readies and valids are 0; `busy = 0`; `grant_idx = 0`.
- Arbitration latency is 1 cycle: a request seen in IDLE at cycle t appears on `s` at cycle t+1.
- Minimum read is 3 cycles IDLE→IDLE, with zero-wait slave (arbitrate, AR, R). Minimum write is also 3 cycles (arbitrate, AW+W, B).
- After a completion, the next arbitration happens in the following IDLE cycle, so there is one dead cycle between transactions.
- Masters must hold `valid` and payload until their handshake, per AXI. The arbiter does not buffer.
- Reset asserted in any state returns to IDLE on the next edge. In-flight `s` transactions are abandoned; the downstream slave is reset by the same signal.
- A master that drops its request before the grant takes effect is a protocol violation. The behaviour in that case is undefined but must not deadlock past reset.

## Test plan
- Single read, zero-wait slave returning 0xDEADBEEF:
  - Stimulus: m0 `arvalid` with `araddr=0x80000000` at cycle 0.
  - Response: `s.arvalid=1` at cycle 1; `m[0].rvalid=1` with rdata 0xDEADBEEF at cycle 2; `busy` back to 0 at cycle 3.
- Contention on reads:
  - Stimulus: m0 and m1 both issue reads continuously after reset.
  - Response: grant order 0,1,0,1; `m[1].rvalid` stays 0 throughout every m0 transaction.
- Split write handshakes:
  - Stimulus: m1 write of 0x12345678 with mask 4'b1111 to 0xa00003f8. Slave `wready` is immediate; `awready` is delayed 3 cycles.
  - Response: W completes first and `s.wvalid` drops afterwards. WR_B is entered only after AW completes. m1 sees `bvalid` with bresp 00.
- Same-cycle AW/W completion:
  - Stimulus: both AW and W handshake in the same cycle.
  - Response: WR_B is entered on the next edge with no extra cycle.
- Read precedence within one master:
  - Stimulus: m0 asserts `arvalid` and `awvalid` together, with no other requester.
  - Response: the read is served first, then the write in the next arbitration. The pointer wraps, so m0 is granted again.
- Reset mid-read:
  - Stimulus: reset asserted while in RD_R.
  - Response: next cycle `s.rready=0`, `busy=0`, all `m` valids 0. The first request after reset goes to m0.
